// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: merges NCH SRAM-like masters onto one slave port and
// returns in-order responses to the originating channel through an ID FIFO.
module sram_req_arbiter #(
    parameter int NCH         = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int OUTSTANDING = 4,
    parameter int RR_MODE     = 1
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic [NCH-1:0]                     m_req,
    input  logic [NCH-1:0]                     m_wr,
    input  logic [NCH*DATA_W/8-1:0]            m_wstrb,
    input  logic [NCH*ADDR_W-1:0]              m_addr,
    input  logic [NCH*DATA_W-1:0]              m_wdata,
    output logic [NCH-1:0]                     m_addr_ok,
    output logic [NCH-1:0]                     m_data_ok,
    output logic [DATA_W-1:0]                  m_rdata,
    output logic                               s_req,
    output logic                               s_wr,
    output logic [DATA_W/8-1:0]                s_wstrb,
    output logic [ADDR_W-1:0]                  s_addr,
    output logic [DATA_W-1:0]                  s_wdata,
    input  logic                               s_addr_ok,
    input  logic                               s_data_ok,
    input  logic [DATA_W-1:0]                  s_rdata,
    output logic [$clog2(OUTSTANDING+1)-1:0]   pending,
    output logic                               err
);
    localparam int IDW = $clog2(NCH);
    localparam int PW  = $clog2(OUTSTANDING + 1);
    localparam int AW  = $clog2(OUTSTANDING);
    localparam int SW  = DATA_W / 8;

    logic [IDW-1:0] r_rr;
    logic [IDW-1:0] r_fifo [OUTSTANDING];
    logic [AW-1:0]  r_wp, r_rp;
    logic [PW-1:0]  r_cnt;
    logic           r_err;
    logic [IDW-1:0] w_lo, w_hi, w_gnt, w_gnt_nxt;
    logic           w_hi_ok, w_full, w_empty, w_acc, w_pop;

    // w_hi: lowest requester at/above the pointer; w_lo: lowest overall (wrap case).
    // In fixed-priority mode the pointer stays 0, so w_hi is simply the lowest index.
    always_comb begin
        w_lo    = '0;
        w_hi    = '0;
        w_hi_ok = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m_req[i]) w_lo = IDW'(i);
            if (m_req[i] && i >= int'(r_rr)) begin
                w_hi    = IDW'(i);
                w_hi_ok = 1'b1;
            end
        end
    end

    assign w_gnt     = w_hi_ok ? w_hi : w_lo;
    assign w_gnt_nxt = (w_gnt == IDW'(NCH - 1)) ? '0 : w_gnt + 1'b1;
    assign w_full    = r_cnt == PW'(OUTSTANDING);
    assign w_empty   = r_cnt == '0;
    assign w_acc     = s_req & s_addr_ok;
    assign w_pop     = s_data_ok & ~w_empty;

    assign s_req     = (|m_req) & ~w_full;
    assign s_wr      = s_req & m_wr[w_gnt];
    assign s_wstrb   = s_req ? m_wstrb[w_gnt*SW +: SW] : '0;
    assign s_addr    = s_req ? m_addr[w_gnt*ADDR_W +: ADDR_W] : '0;
    assign s_wdata   = s_req ? m_wdata[w_gnt*DATA_W +: DATA_W] : '0;
    assign m_addr_ok = w_acc ? NCH'(1) << w_gnt : '0;
    assign m_data_ok = w_pop ? NCH'(1) << r_fifo[r_rp] : '0;
    assign m_rdata   = s_rdata;
    assign pending   = r_cnt;
    assign err       = r_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rr  <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_acc) r_wp <= r_wp + 1'b1;
            if (w_acc && RR_MODE != 0) r_rr <= w_gnt_nxt;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + PW'(w_acc) - PW'(w_pop);
            if (s_data_ok && w_empty) r_err <= 1'b1;
        end
    end

    // ID storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_acc) r_fifo[r_wp] <= w_gnt;
    end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter: directed stimulus with a scoreboard of expected accepts
// and responses, for a round-robin and a fixed-priority instance.
module tb_sram_req_arbiter;
    typedef logic [70:0] acc_t;
    localparam logic [31:0] A0 = 32'h0000_0100, A1 = 32'h0000_0200, WD1 = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [1:0] m_req, m_wr, m_addr_ok, m_data_ok;
    logic [7:0] m_wstrb;
    logic [63:0] m_addr, m_wdata;
    logic [31:0] m_rdata, s_addr, s_wdata, s_rdata;
    logic s_req, s_wr, s_addr_ok, s_data_ok, err;
    logic [3:0] s_wstrb;
    logic [2:0] pending;

    logic [1:0] f_m_req, f_m_wr, f_m_addr_ok, f_m_data_ok;
    logic [7:0] f_m_wstrb;
    logic [63:0] f_m_addr, f_m_wdata;
    logic [31:0] f_m_rdata, f_s_addr, f_s_wdata, f_s_rdata;
    logic f_s_req, f_s_wr, f_s_addr_ok, f_s_data_ok, f_err;
    logic [3:0] f_s_wstrb;
    logic [2:0] f_pending;

    sram_req_arbiter #(.NCH(2), .ADDR_W(32), .DATA_W(32), .OUTSTANDING(4), .RR_MODE(1)) u_rr (
        .clk(clk), .resetn(resetn), .m_req(m_req), .m_wr(m_wr), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
        .m_rdata(m_rdata), .s_req(s_req), .s_wr(s_wr), .s_wstrb(s_wstrb), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .pending(pending), .err(err));

    sram_req_arbiter #(.NCH(2), .ADDR_W(32), .DATA_W(32), .OUTSTANDING(4), .RR_MODE(0)) u_fp (
        .clk(clk), .resetn(resetn), .m_req(f_m_req), .m_wr(f_m_wr), .m_wstrb(f_m_wstrb),
        .m_addr(f_m_addr), .m_wdata(f_m_wdata), .m_addr_ok(f_m_addr_ok), .m_data_ok(f_m_data_ok),
        .m_rdata(f_m_rdata), .s_req(f_s_req), .s_wr(f_s_wr), .s_wstrb(f_s_wstrb), .s_addr(f_s_addr),
        .s_wdata(f_s_wdata), .s_addr_ok(f_s_addr_ok), .s_data_ok(f_s_data_ok), .s_rdata(f_s_rdata),
        .pending(f_pending), .err(f_err));

    acc_t qa[$], fqa[$];
    logic [33:0] qd[$], fqd[$];
    int checks = 0, passes = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic acc_t ea(input logic [1:0] ok, input logic [31:0] addr, input logic wr,
                                input logic [3:0] st, input logic [31:0] wd);
        return {ok, wr, st, addr, wd};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (m_addr_ok !== 2'b00)
                chk("addr_ok", {m_addr_ok, s_wr, s_wstrb, s_addr, s_wdata}, qa.size() != 0 ? qa.pop_front() : '0);
            if (m_data_ok !== 2'b00)
                chk("data_ok", {m_data_ok, m_rdata}, qd.size() != 0 ? qd.pop_front() : '0);
            if (f_m_addr_ok !== 2'b00)
                chk("fp_addr_ok", {f_m_addr_ok, f_s_wr, f_s_wstrb, f_s_addr, f_s_wdata}, fqa.size() != 0 ? fqa.pop_front() : '0);
            if (f_m_data_ok !== 2'b00)
                chk("fp_data_ok", {f_m_data_ok, f_m_rdata}, fqd.size() != 0 ? fqd.pop_front() : '0);
        end
    end

    initial begin
        acc_t e0, e1, f0, f1;
        logic [31:0] rd;
        e0 = ea(2'b01, A0, 1'b0, 4'h0, 32'h0);
        e1 = ea(2'b10, A1, 1'b1, 4'hF, WD1);
        f0 = ea(2'b01, A0, 1'b0, 4'h0, 32'h0);
        f1 = ea(2'b10, A1, 1'b0, 4'h0, 32'h0);
        resetn = 1'b0;
        m_req = 2'b00; m_wr = 2'b10; m_wstrb = 8'hF0; m_addr = {A1, A0}; m_wdata = {WD1, 32'h0};
        s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
        f_m_req = 2'b00; f_m_wr = 2'b00; f_m_wstrb = 8'h00; f_m_addr = {A1, A0}; f_m_wdata = '0;
        f_s_addr_ok = 1'b0; f_s_data_ok = 1'b0; f_s_rdata = '0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_idle", {s_req, s_addr, pending, err, m_addr_ok, m_data_ok}, '0);
        end
        // round-robin fill until full
        tick; resetn = 1'b1; m_req = 2'b11; s_addr_ok = 1'b1; qa.push_back(e0);
        for (int i = 1; i < 4; i++) begin
            tick; qa.push_back((i % 2 != 0) ? e1 : e0);
        end
        tick;
        @(negedge clk); chk("full_blocks", {s_req, m_addr_ok, pending}, {1'b0, 2'b00, 3'd4});
        // pop while full: no accept in the same cycle
        tick; s_data_ok = 1'b1; s_rdata = 32'h11; qd.push_back({2'b01, 32'h11});
        @(negedge clk); chk("full_pop", {s_req, m_addr_ok, pending}, {1'b0, 2'b00, 3'd4});
        tick; s_data_ok = 1'b0; qa.push_back(e0);
        @(negedge clk); chk("after_pop", {s_req, pending}, {1'b1, 3'd3});
        tick; m_req = 2'b00; s_addr_ok = 1'b0;
        @(negedge clk); chk("refill", {s_req, pending}, {1'b0, 3'd4});
        for (int i = 0; i < 4; i++) begin
            tick; s_data_ok = 1'b1; rd = 32'h22 + 32'(i) * 32'h11; s_rdata = rd;
            qd.push_back({(i % 2 != 0) ? 2'b01 : 2'b10, rd});
        end
        tick; s_data_ok = 1'b0;
        @(negedge clk); chk("drained", {pending, err}, {3'd0, 1'b0});
        // slave stall
        tick; m_addr[31:0] = 32'h1FC0_0000; m_req = 2'b01;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); chk("stall", {s_req, s_addr, m_addr_ok}, {1'b1, 32'h1FC0_0000, 2'b00});
            tick;
        end
        s_addr_ok = 1'b1; qa.push_back(ea(2'b01, 32'h1FC0_0000, 1'b0, 4'h0, 32'h0));
        tick; s_addr_ok = 1'b0; m_req = 2'b00;
        @(negedge clk); chk("stall_accept", pending, 3'd1);
        tick; s_data_ok = 1'b1; s_rdata = 32'h77; qd.push_back({2'b01, 32'h77});
        tick; s_data_ok = 1'b0;
        @(negedge clk); chk("stall_done", pending, 3'd0);
        // response with nothing outstanding
        tick; s_data_ok = 1'b1; s_rdata = 32'h99;
        @(negedge clk); chk("err_resp", {m_data_ok, err}, {2'b00, 1'b0});
        tick; s_data_ok = 1'b0;
        @(negedge clk); chk("err_set", err, 1'b1);
        repeat (3) tick;
        @(negedge clk); chk("err_sticky", err, 1'b1);
        tick; resetn = 1'b0; #1;
        chk("err_cleared", {err, pending}, {1'b0, 3'd0});
        // response in the same cycle as the first accept is an error
        tick; resetn = 1'b1; m_addr[31:0] = A0; m_req = 2'b01; s_addr_ok = 1'b1;
        s_data_ok = 1'b1; s_rdata = 32'h5A; qa.push_back(e0);
        @(negedge clk); chk("same_cyc_resp", m_data_ok, 2'b00);
        tick; m_req = 2'b00; s_addr_ok = 1'b0; s_data_ok = 1'b0;
        @(negedge clk); chk("same_cyc_err", {err, pending}, {1'b1, 3'd1});
        // reset discards in-flight IDs
        tick; resetn = 1'b0;
        tick; resetn = 1'b1;
        @(negedge clk); chk("mid_reset", {err, pending, s_req}, {1'b0, 3'd0, 1'b0});
        // fixed priority: channel 1 starved while channel 0 requests
        tick; f_m_req = 2'b11; f_s_addr_ok = 1'b1; fqa.push_back(f0);
        for (int i = 1; i < 6; i++) begin
            tick; f_s_data_ok = 1'b1; f_s_rdata = 32'(i);
            fqa.push_back(f0); fqd.push_back({2'b01, 32'(i)});
            @(negedge clk); chk("fp_pending", f_pending, 3'd1);
        end
        tick; f_m_req = 2'b10; f_s_rdata = 32'h9; fqa.push_back(f1); fqd.push_back({2'b01, 32'h9});
        tick; f_m_req = 2'b00; f_s_addr_ok = 1'b0; f_s_rdata = 32'hA; fqd.push_back({2'b10, 32'hA});
        tick; f_s_data_ok = 1'b0;
        @(negedge clk); chk("fp_done", {f_pending, f_err}, {3'd0, 1'b0});
        chk("qa_empty", qa.size(), 0);
        chk("qd_empty", qd.size(), 0);
        chk("fqa_empty", fqa.size(), 0);
        chk("fqd_empty", fqd.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
N-channel arbiter merging independent SRAM-like request/response ports, e.g. IF instruction and EXE/MEM data, onto one shared SRAM-like slave port. It is the multi-master front end for the pipelined core, sitting between the stage logic and a single unified memory/bus bridge. It supports configurable channel count, round-robin or fixed priority, and up to OUTSTANDING in-flight transactions. Responses are returned in order to the originating channel via an internal ID FIFO.

Parameters:
NCH, 2, number of master channels (2..8); channel 0 = instruction fetch.
ADDR_W, 32, address width.
DATA_W, 32, data width (multiple of 8).
OUTSTANDING, 4, max accepted-but-unanswered transactions; power of 2, 2..16.
RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).

Ports:
clk  in  1  clock; all state updates on rising edge.
resetn  in  1  asynchronous, active-low reset.
m_req  in  NCH  per-channel request valid.
m_wr  in  NCH  per-channel write (1) / read (0).
m_wstrb  in  NCH*DATA_W/8  per-channel byte strobes; channel i at slice i.
m_addr  in  NCH*ADDR_W  per-channel address.
m_wdata  in  NCH*DATA_W  per-channel write data.
m_addr_ok  out  NCH  one-hot request-accepted pulse.
m_data_ok  out  NCH  one-hot response pulse.
m_rdata  out  DATA_W  read data, broadcast; valid with any m_data_ok.
s_req  out  1  slave request valid.
s_wr  out  1  slave write.
s_wstrb  out  DATA_W/8  slave strobes.
s_addr  out  ADDR_W  slave address.
s_wdata  out  DATA_W  slave write data.
s_addr_ok  in  1  slave accepts request this cycle.
s_data_ok  in  1  slave response this cycle (in order).
s_rdata  in  DATA_W  slave read data.
pending  out  $clog2(OUTSTANDING+1)  current in-flight count.
err  out  1  sticky protocol error.

Behaviour:
- Reset (resetn=0, asynchronous): ID FIFO empty, pending=0, rr pointer=0, err=0. With the FIFO empty, combinational outputs follow the rules below; s_req=0 whenever m_req=0.
- Grant: combinational.
  - RR_MODE=1: first asserted m_req at or after rr pointer, wrapping NCH-1 -> 0.
  - RR_MODE=0: lowest asserted index.
- s_req = (|m_req) & ~full, where full = (pending == OUTSTANDING). s_wr/s_wstrb/s_addr/s_wdata are muxed from the granted channel; 0 when s_req=0.
- Accept = s_req & s_addr_ok. The granted bit of m_addr_ok is high in the same cycle; all others 0. m_addr_ok=0 when full, even if s_addr_ok=1.
- On accept: push grant index into the ID FIFO. RR_MODE=1: rr pointer <= (grant+1) mod NCH. With no accept, the pointer holds.
- Masters hold request fields stable until m_addr_ok. A request may be withdrawn before acceptance; the arbiter does not latch unaccepted requests.
- Response: when s_data_ok=1 and FIFO non-empty:
  - m_data_ok[head]=1 and m_rdata=s_rdata in the same cycle (zero added latency);
  - pop at clock edge.
  - m_rdata=s_rdata at all times; meaningful only with m_data_ok.
- s_data_ok with FIFO empty at the start of the cycle: ignored (no m_data_ok) and err<=1. This includes a response in the same cycle as the first accept, since the slave must respond at least one cycle after accept. err clears only on reset.
- Simultaneous accept and pop: both take effect and pending is unchanged. full is computed from the registered pending, so a pop does not enable an accept in the same cycle.
- pending = FIFO occupancy; pointers wrap modulo OUTSTANDING; never exceeds OUTSTANDING.
- Reset mid-transaction: all in-flight IDs are discarded. Any later s_data_ok for them sets err. The system must reset the slave concurrently.

Test Plan:
- Reset then idle: resetn low 3 cycles, m_req=0 -> s_req=0, pending=0, err=0, all m_* outputs 0.
- Round-robin, NCH=2, RR_MODE=1, both m_req held, s_addr_ok=1 every cycle -> grants alternate 0,1,0,1; pending reaches 4 and s_req drops; then s_data_ok for 4 cycles with s_rdata=0x11,0x22,0x33,0x44 -> m_data_ok = 01,10,01,10 with matching m_rdata.
- Fixed priority, RR_MODE=0, both m_req held, s_addr_ok=1, s_data_ok=1 one cycle after each accept -> channel 1 never granted while channel 0 requests.
- Full-with-pop, pending=4: s_data_ok=1 and s_addr_ok=1 in the same cycle -> one pop, no accept, pending=3; next cycle accept, pending=4.
- Slave stall: s_addr_ok=0 for 5 cycles with m_req=01, addr=0x1FC00000 -> s_req=1, s_addr=0x1FC00000 stable, m_addr_ok=0; on s_addr_ok=1 -> m_addr_ok=01, pending=1.
- Protocol error: s_data_ok=1 with pending=0 -> no m_data_ok, err=1 next cycle and remains 1 until resetn=0.
